// File: rtl/bus_arbiter_if.sv
// Core-side and gpiomem-side signals of the two-master arbiter, bundled as one interface.
// The slave modport is the arbiter's view; the master modport is the cores/gpiomem view.
interface bus_arbiter_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RAM_ADDR_W = 9
);
  logic                  core0_request;
  logic                  core0_grant;
  logic [DATA_W-1:0]     core0_data_in;
  logic [DATA_W-1:0]     core0_data_out;
  logic [ADDR_W-1:0]     core0_address;
  logic                  core0_rw;

  logic                  core1_request;
  logic                  core1_grant;
  logic [DATA_W-1:0]     core1_data_in;
  logic [DATA_W-1:0]     core1_data_out;
  logic [ADDR_W-1:0]     core1_address;
  logic                  core1_rw;

  logic [RAM_ADDR_W-1:0] RAM_address;
  logic [DATA_W-1:0]     RAM_data_in;
  logic [DATA_W-1:0]     RAM_data_out;
  logic                  rw;
  logic [1:0]            owner;

  modport slave (
    input  core0_request, core0_data_in, core0_address, core0_rw,
    output core0_grant, core0_data_out,
    input  core1_request, core1_data_in, core1_address, core1_rw,
    output core1_grant, core1_data_out,
    output RAM_address, RAM_data_in, rw, owner,
    input  RAM_data_out
  );

  modport master (
    output core0_request, core0_data_in, core0_address, core0_rw,
    input  core0_grant, core0_data_out,
    output core1_request, core1_data_in, core1_address, core1_rw,
    input  core1_grant, core1_data_out,
    input  RAM_address, RAM_data_in, rw, owner,
    output RAM_data_out
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and data-path mux giving core0/core1 exclusive access to gpiomem,
// with optional hold-time preemption and a one-cycle turnaround between owners.
module bus_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RAM_ADDR_W = 9,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10,
    TURN = 2'b11
  } state_t;

  state_t           state, state_next;
  logic             last, last_next;
  logic [CNT_W-1:0] hold_cnt, hold_next;
  logic             oor_q, oor_next;
  logic             oor0, oor1;
  logic             preempt0, preempt1;

  // Round-robin pick: on a tie the core that was not served last wins.
  function automatic state_t arbitrate(input logic r0, input logic r1, input logic lst);
    if (r0 && r1) return lst ? OWN0 : OWN1;
    if (r0)       return OWN0;
    if (r1)       return OWN1;
    return IDLE;
  endfunction

  always_comb begin
    oor0     = (bus.core0_address >> RAM_ADDR_W) != '0;
    oor1     = (bus.core1_address >> RAM_ADDR_W) != '0;
    preempt0 = PREEMPT_EN && bus.core1_request && (hold_cnt == HOLD_LAST);
    preempt1 = PREEMPT_EN && bus.core0_request && (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
      oor_q    <= 1'b0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      hold_cnt <= hold_next;
      oor_q    <= oor_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last;
    hold_next  = hold_cnt;
    case (state)
      IDLE, TURN: state_next = arbitrate(bus.core0_request, bus.core1_request, last);
      OWN0: begin
        if (!bus.core0_request || preempt0) begin
          state_next = TURN;
          last_next  = 1'b0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      OWN1: begin
        if (!bus.core1_request || preempt1) begin
          state_next = TURN;
          last_next  = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if ((state_next == OWN0 || state_next == OWN1) && state_next != state)
      hold_next = '0;
  end

  // Data path is a pure mux on the registered state; no owner means an all-zero bus.
  always_comb begin
    bus.core0_grant    = (state == OWN0);
    bus.core1_grant    = (state == OWN1);
    bus.RAM_address    = '0;
    bus.RAM_data_in    = '0;
    bus.rw             = 1'b0;
    bus.owner          = 2'b00;
    bus.core0_data_out = '0;
    bus.core1_data_out = '0;
    oor_next           = 1'b0;
    case (state)
      OWN0: begin
        bus.owner          = 2'b01;
        bus.RAM_address    = bus.core0_address[RAM_ADDR_W-1:0];
        bus.RAM_data_in    = bus.core0_data_in;
        bus.rw             = bus.core0_rw && !oor0;
        bus.core0_data_out = oor_q ? '0 : bus.RAM_data_out;
        oor_next           = oor0;
      end
      OWN1: begin
        bus.owner          = 2'b10;
        bus.RAM_address    = bus.core1_address[RAM_ADDR_W-1:0];
        bus.RAM_data_in    = bus.core1_data_in;
        bus.rw             = bus.core1_rw && !oor1;
        bus.core1_data_out = oor_q ? '0 : bus.RAM_data_out;
        oor_next           = oor1;
      end
      default: ;
    endcase
  end

  a_one_grant: assert property (@(posedge clk) !(bus.core0_grant && bus.core1_grant));
  a_no_idle_write: assert property (@(posedge clk)
    (state == IDLE || state == TURN) |-> !bus.rw);

endmodule
